// File: rtl/accum_ctrl_pkg.sv
// Shared types for the accumulate sequencer.
// FSM state encoding and the add/subtract opcode values.
package accum_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/accum_seq_ctrl_if.sv
// Command / operand / result handshakes of accum_seq_ctrl.
// slave = sequencer side, master = source/consumer side.
interface accum_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             i_cmd_valid;
  logic             o_cmd_ready;
  logic             i_cmd_sub;
  logic [CNT_W-1:0] i_cmd_len;
  logic             i_op_valid;
  logic             o_op_ready;
  logic [WIDTH-1:0] i_op_data;
  logic             o_res_valid;
  logic             i_res_ready;
  logic [WIDTH-1:0] o_res_data;
  logic             o_res_carry;
  logic             o_res_ovf;
  logic             o_busy;

  modport slave (
    input  i_cmd_valid, i_cmd_sub, i_cmd_len,
    input  i_op_valid, i_op_data, i_res_ready,
    output o_cmd_ready, o_op_ready, o_res_valid,
    output o_res_data, o_res_carry, o_res_ovf,
    output o_busy
  );

  modport master (
    output i_cmd_valid, i_cmd_sub, i_cmd_len,
    output i_op_valid, i_op_data, i_res_ready,
    input  o_cmd_ready, o_op_ready, o_res_valid,
    input  o_res_data, o_res_carry, o_res_ovf,
    input  o_busy
  );
endinterface

// File: rtl/add_subtract.sv
// Combinational WIDTH-bit adder/subtractor (a - b when add_sub=1).
// o_carry: carry-out (no borrow on subtract); o_ovf: signed overflow.
module add_subtract
  import accum_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             add_sub,
  output logic [WIDTH-1:0] result_o,
  output logic             o_carry,
  output logic             o_ovf
);

  logic             sub;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   sum;

  assign sub = (add_sub == OP_SUB);
  assign b_x = sub ? ~b_i : b_i;
  assign sum = {1'b0, a_i} + {1'b0, b_x}
             + {{WIDTH{1'b0}}, sub};

  assign result_o = sum[WIDTH-1:0];
  assign o_carry  = sum[WIDTH];
  // Overflow: both effective inputs share a sign the result lacks.
  assign o_ovf = (a_i[WIDTH-1] == b_x[WIDTH-1])
              && (sum[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/accum_seq_ctrl.sv
// Burst accumulate sequencer around add_subtract.
// Ports: i_clk, i_rst (async high), bus (cmd/op/res handshakes).
module accum_seq_ctrl
  import accum_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  accum_seq_ctrl_if.slave  bus
);

  state_e           state_q, state_d;
  logic             sub_q, sub_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             cmd_rdy_q, cmd_rdy_d;
  logic             op_rdy_q, op_rdy_d;
  logic             res_vld_q, res_vld_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] as_res;
  logic             as_carry;
  logic             as_ovf;

  add_subtract #(.WIDTH(WIDTH)) u_as (
    .a_i      (acc_q),
    .b_i      (bus.i_op_data),
    .add_sub  (sub_q),
    .result_o (as_res),
    .o_carry  (as_carry),
    .o_ovf    (as_ovf)
  );

  always_comb begin
    state_d = state_q;
    sub_d   = sub_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_cmd_valid && cmd_rdy_q) begin
          sub_d   = bus.i_cmd_sub;
          rem_d   = bus.i_cmd_len;
          acc_d   = '0;
          carry_d = 1'b0;
          ovf_d   = 1'b0;
          state_d = (bus.i_cmd_len == '0)
                  ? DONE : ACC;
        end
      end
      ACC: begin
        if (bus.i_op_valid && op_rdy_q) begin
          acc_d   = as_res;
          carry_d = as_carry;
          ovf_d   = ovf_q | as_ovf;
          rem_d   = rem_q - 1'b1;
          if (rem_q == CNT_W'(1))
            state_d = DONE;
        end
      end
      DONE: begin
        if (bus.i_res_ready && res_vld_q)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake outputs are registered decodes of the next state.
    cmd_rdy_d = (state_d == IDLE);
    op_rdy_d  = (state_d == ACC);
    res_vld_d = (state_d == DONE);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      sub_q     <= 1'b0;
      rem_q     <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      ovf_q     <= 1'b0;
      cmd_rdy_q <= 1'b1;
      op_rdy_q  <= 1'b0;
      res_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sub_q     <= sub_d;
      rem_q     <= rem_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      ovf_q     <= ovf_d;
      cmd_rdy_q <= cmd_rdy_d;
      op_rdy_q  <= op_rdy_d;
      res_vld_q <= res_vld_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.o_cmd_ready = cmd_rdy_q;
  assign bus.o_op_ready  = op_rdy_q;
  assign bus.o_res_valid = res_vld_q;
  assign bus.o_res_data  = acc_q;
  assign bus.o_res_carry = carry_q;
  assign bus.o_res_ovf   = ovf_q;
  assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// Directed bench for accum_seq_ctrl.
// Inputs driven and outputs sampled on the falling edge.
module tb_accum_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_op = 0;
  int   n_cmd = 0;
  int   op_base;
  int   cmd_base;

  always #5 clk = ~clk;

  accum_seq_ctrl_if b();

  accum_seq_ctrl dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (b)
  );

  always @(posedge clk) begin
    if (b.i_op_valid && b.o_op_ready)
      n_op = n_op + 1;
    if (b.i_cmd_valid && b.o_cmd_ready)
      n_cmd = n_cmd + 1;
  end

  task automatic chk(string tag,
                     logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, got, exp);
  endtask

  task automatic send_cmd(logic sub,
                          logic [3:0] len);
    b.i_cmd_valid = 1'b1;
    b.i_cmd_sub   = sub;
    b.i_cmd_len   = len;
    for (int n = 0; n < 20 && !b.o_cmd_ready; n++)
      @(negedge clk);
    chk("cmd_rdy", 32'(b.o_cmd_ready), 1);
    @(negedge clk);
    b.i_cmd_valid = 1'b0;
  endtask

  task automatic send_op(logic [7:0] d);
    b.i_op_valid = 1'b1;
    b.i_op_data  = d;
    for (int n = 0; n < 20 && !b.o_op_ready; n++)
      @(negedge clk);
    chk("op_rdy", 32'(b.o_op_ready), 1);
    @(negedge clk);
    b.i_op_valid = 1'b0;
  endtask

  task automatic get_res(logic [7:0] d,
                         logic c, logic v);
    chk("res_vld", 32'(b.o_res_valid), 1);
    chk("res_data", 32'(b.o_res_data), 32'(d));
    chk("res_carry", 32'(b.o_res_carry), 32'(c));
    chk("res_ovf", 32'(b.o_res_ovf), 32'(v));
    b.i_res_ready = 1'b1;
    @(negedge clk);
    b.i_res_ready = 1'b0;
    chk("post_vld", 32'(b.o_res_valid), 0);
    chk("post_busy", 32'(b.o_busy), 0);
    chk("post_crdy", 32'(b.o_cmd_ready), 1);
  endtask

  initial begin
    rst = 1'b1;
    b.i_cmd_valid = 1'b0;
    b.i_cmd_sub   = 1'b0;
    b.i_cmd_len   = '0;
    b.i_op_valid  = 1'b0;
    b.i_op_data   = '0;
    b.i_res_ready = 1'b0;
    #1;
    chk("rst_crdy", 32'(b.o_cmd_ready), 1);
    chk("rst_ordy", 32'(b.o_op_ready), 0);
    chk("rst_vld", 32'(b.o_res_valid), 0);
    chk("rst_busy", 32'(b.o_busy), 0);
    chk("rst_data", 32'(b.o_res_data), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: add 10+20+30
    send_cmd(1'b0, 4'd3);
    chk("t1_busy", 32'(b.o_busy), 1);
    send_op(8'd10);
    send_op(8'd20);
    chk("t1_early", 32'(b.o_res_valid), 0);
    send_op(8'd30);
    get_res(8'd60, 1'b0, 1'b0);

    // 2: 0-5-3
    send_cmd(1'b1, 4'd2);
    send_op(8'd5);
    send_op(8'd3);
    get_res(8'hF8, 1'b1, 1'b0);

    // 3: sticky overflow
    send_cmd(1'b0, 4'd3);
    send_op(8'd100);
    send_op(8'd100);
    chk("t3_mid_ovf", 32'(b.o_res_ovf), 1);
    send_op(8'd200);
    get_res(8'd144, 1'b1, 1'b1);

    // 4: zero-length burst, stalled consumer
    send_cmd(1'b0, 4'd0);
    for (int i = 0; i < 5; i++) begin
      chk("t4_vld", 32'(b.o_res_valid), 1);
      chk("t4_data", 32'(b.o_res_data), 0);
      chk("t4_crdy", 32'(b.o_cmd_ready), 0);
      chk("t4_busy", 32'(b.o_busy), 1);
      @(negedge clk);
    end
    get_res(8'd0, 1'b0, 1'b0);

    // 5: operand gaps, second cmd held off
    op_base  = n_op;
    cmd_base = n_cmd;
    send_cmd(1'b0, 4'd4);
    b.i_cmd_valid = 1'b1;
    b.i_cmd_sub   = 1'b1;
    b.i_cmd_len   = 4'd1;
    for (int i = 0; i < 10; i++) begin
      b.i_op_valid = (i % 2 == 0);
      b.i_op_data  = 8'(i / 2 + 1);
      chk("t5_crdy", 32'(b.o_cmd_ready), 0);
      @(negedge clk);
    end
    b.i_op_valid = 1'b0;
    chk("t5_nops", 32'(n_op - op_base), 4);
    chk("t5_ncmd", 32'(n_cmd - cmd_base), 1);
    get_res(8'd10, 1'b0, 1'b0);
    @(negedge clk);
    b.i_cmd_valid = 1'b0;
    chk("t5_ncmd2", 32'(n_cmd - cmd_base), 2);
    chk("t5_busy2", 32'(b.o_busy), 1);
    send_op(8'd9);
    get_res(8'hF7, 1'b0, 1'b0);

    // 6: reset mid-burst
    send_cmd(1'b0, 4'd5);
    send_op(8'd1);
    send_op(8'd2);
    rst = 1'b1;
    #1;
    chk("t6_crdy", 32'(b.o_cmd_ready), 1);
    chk("t6_ordy", 32'(b.o_op_ready), 0);
    chk("t6_vld", 32'(b.o_res_valid), 0);
    chk("t6_data", 32'(b.o_res_data), 0);
    chk("t6_busy", 32'(b.o_busy), 0);
    chk("t6_ovf", 32'(b.o_res_ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_cmd(1'b0, 4'd1);
    send_op(8'd7);
    get_res(8'd7, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
